// File: rtl/ts_measure_engine.sv
// Measure-handshake responder: settles, acquires N samples onto AXI-Stream,
// stamps the first sample with RTC time and reports completion.
module ts_measure_engine #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           rtc_sec,
    input  logic [31:0]           rtc_nsec,
    input  logic                  measure_start,
    output logic                  measure_ready,
    output logic                  measure_done,
    input  logic                  ctrl_abort,
    input  logic [31:0]           ctrl_settle_cycles,
    input  logic [31:0]           ctrl_sample_count,
    input  logic [DATA_WIDTH-1:0] s_data_tdata,
    input  logic                  s_data_tvalid,
    output logic [DATA_WIDTH-1:0] m_data_tdata,
    output logic                  m_data_tvalid,
    input  logic                  m_data_tready,
    output logic                  m_data_tlast,
    output logic [31:0]           stat_ts_sec,
    output logic [31:0]           stat_ts_nsec,
    output logic [31:0]           stat_meas_count,
    output logic                  stat_overrun,
    output logic                  stat_busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           settle_cnt_q, settle_cnt_d;
    logic [31:0]           n_samp_q, n_samp_d;
    logic [31:0]           samp_cnt_q, samp_cnt_d;
    logic [31:0]           ts_sec_q, ts_sec_d;
    logic [31:0]           ts_nsec_q, ts_nsec_d;
    logic [31:0]           meas_cnt_q, meas_cnt_d;
    logic                  ovr_q, ovr_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  busy_q;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  out_free;
    logic                  out_fire;

    assign out_free = !m_valid_q || m_data_tready;
    assign out_fire = m_valid_q && m_data_tready;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        n_samp_d     = n_samp_q;
        samp_cnt_d   = samp_cnt_q;
        ts_sec_d     = ts_sec_q;
        ts_nsec_d    = ts_nsec_q;
        meas_cnt_d   = meas_cnt_q;
        ovr_d        = ovr_q;
        ready_d      = 1'b0;
        done_d       = 1'b0;
        m_data_d     = m_data_q;
        // A completed handshake empties the output register unless reloaded below.
        m_valid_d    = m_valid_q && !out_fire;
        m_last_d     = m_last_q && !out_fire;

        if (ctrl_abort) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (measure_start) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = ctrl_settle_cycles;
                        n_samp_d     = (ctrl_sample_count == 32'd0) ? 32'd1 : ctrl_sample_count;
                        samp_cnt_d   = 32'd0;
                        ovr_d        = 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (!measure_start) begin
                        state_d = ST_IDLE;
                    end else if (settle_cnt_q != 32'd0) begin
                        settle_cnt_d = settle_cnt_q - 32'd1;
                    end else begin
                        state_d = ST_ACQUIRE;
                        ready_d = 1'b1;
                    end
                end
                ST_ACQUIRE: begin
                    if (s_data_tvalid) begin
                        if (out_free) begin
                            m_data_d   = s_data_tdata;
                            m_valid_d  = 1'b1;
                            m_last_d   = (samp_cnt_q == n_samp_q - 32'd1);
                            samp_cnt_d = samp_cnt_q + 32'd1;
                            if (samp_cnt_q == 32'd0) begin
                                ts_sec_d  = rtc_sec;
                                ts_nsec_d = rtc_nsec;
                            end
                            if (samp_cnt_q == n_samp_q - 32'd1) begin
                                state_d = ST_FLUSH;
                            end
                        end else begin
                            // No backpressure upstream: a sample that cannot be held is lost.
                            ovr_d = 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (out_fire && m_last_q) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        meas_cnt_d = meas_cnt_q + 32'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= 32'd0;
            n_samp_q     <= 32'd0;
            samp_cnt_q   <= 32'd0;
            ts_sec_q     <= 32'd0;
            ts_nsec_q    <= 32'd0;
            meas_cnt_q   <= 32'd0;
            ovr_q        <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            n_samp_q     <= n_samp_d;
            samp_cnt_q   <= samp_cnt_d;
            ts_sec_q     <= ts_sec_d;
            ts_nsec_q    <= ts_nsec_d;
            meas_cnt_q   <= meas_cnt_d;
            ovr_q        <= ovr_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            busy_q       <= (state_d != ST_IDLE);
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
        end
    end

    assign measure_ready   = ready_q;
    assign measure_done    = done_q;
    assign m_data_tdata    = m_data_q;
    assign m_data_tvalid   = m_valid_q;
    assign m_data_tlast    = m_last_q;
    assign stat_ts_sec     = ts_sec_q;
    assign stat_ts_nsec    = ts_nsec_q;
    assign stat_meas_count = meas_cnt_q;
    assign stat_overrun    = ovr_q;
    assign stat_busy       = busy_q;

endmodule

// File: tb/tb_ts_measure_engine.sv
// Bench for ts_measure_engine: randomized measurements against a reference
// model; expected samples, pulse cycles and status are queued and checked by monitors.
module tb_ts_measure_engine;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   rtc_sec, rtc_nsec;
    logic          measure_start, measure_ready, measure_done, ctrl_abort;
    logic [31:0]   ctrl_settle_cycles, ctrl_sample_count;
    logic [DW-1:0] s_data_tdata, m_data_tdata;
    logic          s_data_tvalid, m_data_tvalid, m_data_tready, m_data_tlast;
    logic [31:0]   stat_ts_sec, stat_ts_nsec, stat_meas_count;
    logic          stat_overrun, stat_busy;

    ts_measure_engine #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .rtc_sec(rtc_sec), .rtc_nsec(rtc_nsec),
        .measure_start(measure_start), .measure_ready(measure_ready),
        .measure_done(measure_done), .ctrl_abort(ctrl_abort),
        .ctrl_settle_cycles(ctrl_settle_cycles), .ctrl_sample_count(ctrl_sample_count),
        .s_data_tdata(s_data_tdata), .s_data_tvalid(s_data_tvalid),
        .m_data_tdata(m_data_tdata), .m_data_tvalid(m_data_tvalid),
        .m_data_tready(m_data_tready), .m_data_tlast(m_data_tlast),
        .stat_ts_sec(stat_ts_sec), .stat_ts_nsec(stat_ts_nsec),
        .stat_meas_count(stat_meas_count), .stat_overrun(stat_overrun),
        .stat_busy(stat_busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [DW:0]   exp_q[$];    // {last, data}
    int            ready_q[$];  // cycle of expected measure_ready
    int            done_q[$];   // cycle of expected measure_done
    logic [96:0]   meta_q[$];   // {ts_sec, ts_nsec, meas_count, overrun}
    logic [31:0]   model_count = 32'd0;
    int            total = 0;
    int            bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s @cycle %0d: event not expected by model", name, cyc);
    endtask

    // ---------------- monitor ----------------
    bit            prev_stall = 1'b0;
    logic [DW:0]   prev_out;
    bit            meta_pending = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            logic [DW:0]  e;
            logic [96:0]  m;
            if (meta_pending) begin
                m = meta_q.pop_front();
                check("ts_sec", stat_ts_sec, m[96:65]);
                check("ts_nsec", stat_ts_nsec, m[64:33]);
                check("meas_count", stat_meas_count, m[32:1]);
                check("overrun", stat_overrun, m[0]);
                meta_pending = 1'b0;
            end
            if (prev_stall && m_data_tvalid)
                check("stall_hold", {m_data_tlast, m_data_tdata}, prev_out);
            if (m_data_tvalid && m_data_tready) begin
                if (exp_q.size() == 0) flag("unexpected_sample");
                else begin
                    e = exp_q.pop_front();
                    check("out_data", m_data_tdata, e[DW-1:0]);
                    check("out_last", m_data_tlast, e[DW]);
                end
            end
            if (measure_ready) begin
                if (ready_q.size() == 0) flag("unexpected_ready");
                else check("ready_cycle", cyc, ready_q.pop_front());
            end
            if (measure_done) begin
                if (done_q.size() == 0) flag("unexpected_done");
                else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    if (meta_q.size() != 0) meta_pending = 1'b1;
                end
            end
            prev_stall = m_data_tvalid && !m_data_tready;
            prev_out   = {m_data_tlast, m_data_tdata};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        rtc_nsec = rtc_nsec + 32'd13;
    endtask

    // One measurement: start in the next cycle, run the reference model over the
    // acquisition window. Returns in the DONE cycle (or the cycle after an abort).
    task automatic run_meas(input int s, input logic [31:0] n_ctrl, input int p_valid,
                            input int p_ready, input int stall, input bit seq,
                            input bit keep, input int abort_at);
        int          n, cnt, t0;
        bit          held, ovr, fin;
        logic [31:0] tsec, tnsec;
        n = (n_ctrl == 32'd0) ? 1 : int'(n_ctrl);
        cnt = 0; held = 1'b0; ovr = 1'b0; fin = 1'b0; tsec = '0; tnsec = '0;
        step();
        measure_start      = 1'b1;
        ctrl_settle_cycles = 32'(s);
        ctrl_sample_count  = n_ctrl;
        t0 = cyc;
        ready_q.push_back(t0 + s + 2);
        for (int i = 0; i < s + 2; i++) begin
            s_data_tvalid = 1'($urandom_range(1));
            s_data_tdata  = DW'($urandom);
            m_data_tready = 1'($urandom_range(1));
            step();
        end
        for (int g = 0; g < 1000 && !fin; g++) begin
            s_data_tvalid = (int'($urandom_range(99)) < p_valid) || g >= 300;
            s_data_tdata  = seq ? DW'(g + 1) : DW'($urandom);
            m_data_tready = (g >= stall) && ((int'($urandom_range(99)) < p_ready) || g >= 300);
            if (g == abort_at) begin
                ctrl_abort    = 1'b1;
                m_data_tready = 1'b0;
                measure_start = 1'b0;
                if (held) void'(exp_q.pop_back());
                step();
                ctrl_abort = 1'b0;
                check("abort_tvalid", m_data_tvalid, held ? 1'b0 : m_data_tvalid);
                check("abort_tlast", m_data_tlast, 1'b0);
                check("abort_busy", stat_busy, 1'b0);
                fin = 1'b1;
            end else if (cnt < n) begin
                if (s_data_tvalid && (!held || m_data_tready)) begin
                    exp_q.push_back({(cnt == n - 1), s_data_tdata});
                    if (cnt == 0) begin
                        tsec  = rtc_sec;
                        tnsec = rtc_nsec;
                    end
                    cnt++;
                    held = 1'b1;
                end else begin
                    if (s_data_tvalid) ovr = 1'b1;
                    if (m_data_tready) held = 1'b0;
                end
                step();
            end else begin
                if (m_data_tready) begin
                    model_count = model_count + 32'd1;
                    done_q.push_back(cyc + 1);
                    meta_q.push_back({tsec, tnsec, model_count, ovr});
                    fin = 1'b1;
                end
                step();
            end
        end
        check("meas_finished", fin, 1'b1);
        if (!keep) measure_start = 1'b0;
    endtask

    task automatic run_drop();
        step();
        measure_start      = 1'b1;
        ctrl_settle_cycles = 32'd20;
        ctrl_sample_count  = 32'd4;
        repeat (8) step();
        check("settle_busy", stat_busy, 1'b1);
        measure_start = 1'b0;
        repeat (3) step();
        check("drop_busy", stat_busy, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        rtc_sec = 32'd0; rtc_nsec = 32'd0;
        measure_start = 1'b0; ctrl_abort = 1'b0;
        ctrl_settle_cycles = '0; ctrl_sample_count = '0;
        s_data_tdata = '0; s_data_tvalid = 1'b0; m_data_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", measure_ready, 1'b0);
        check("rst_done", measure_done, 1'b0);
        check("rst_tvalid", m_data_tvalid, 1'b0);
        check("rst_tlast", m_data_tlast, 1'b0);
        check("rst_tdata", m_data_tdata, '0);
        check("rst_ts", {stat_ts_sec, stat_ts_nsec}, '0);
        check("rst_count", stat_meas_count, '0);
        check("rst_flags", {stat_overrun, stat_busy}, '0);
        rst = 1'b0;
        step();

        // S=0, N=4, continuous data 1..4 with sink always ready
        run_meas(0, 32'd4, 100, 100, 0, 1'b1, 1'b0, -1);
        // timestamp: S=10, N=1 and N=0
        rtc_sec = 32'd5;
        run_meas(10, 32'd1, 100, 100, 0, 1'b0, 1'b0, -1);
        run_meas(10, 32'd0, 60, 100, 0, 1'b0, 1'b0, -1);
        // sink stalled 5 cycles while data streams: overrun
        run_meas(2, 32'd3, 100, 100, 5, 1'b1, 1'b0, -1);
        // start dropped during settle
        run_drop();
        // abort mid-acquire with a held sample, then a normal run
        run_meas(3, 32'd8, 100, 0, 0, 1'b0, 1'b0, 3);
        repeat (2) step();
        run_meas(1, 32'd2, 100, 100, 0, 1'b0, 1'b0, -1);
        // randomized measurements
        for (int k = 0; k < 12; k++) begin
            rtc_sec = $urandom;
            run_meas(int'($urandom_range(6)), 32'($urandom_range(6)),
                     int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                     0, 1'b0, 1'(k % 2), -1);
        end
        // counter wrap with back-to-back starts
        repeat (3) step();
        measure_start = 1'b0;
        force dut.meas_cnt_q = 32'hFFFF_FFFF;
        step();
        release dut.meas_cnt_q;
        model_count = 32'hFFFF_FFFF;
        run_meas(1, 32'd2, 100, 100, 0, 1'b0, 1'b1, -1);
        run_meas(0, 32'd3, 100, 80, 0, 1'b0, 1'b0, -1);

        repeat (5) step();
        check("exp_q_empty", exp_q.size(), 0);
        check("ready_q_empty", ready_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        check("meta_q_empty", meta_q.size(), 0);
        check("final_count", stat_meas_count, model_count);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/ts_measure_engine.md
# ts_measure_engine

Device-side responder for the trigger subsystem's measure handshake. It accepts `measure_start` and waits a programmable settle time. It then returns a one-cycle `measure_ready`, acquires a programmed number of samples from an input stream onto an AXI-Stream output, stamps the first sample with RTC time, and returns a one-cycle `measure_done`. It sits between the trigger core and the ADC/sample path, one instance per measured channel.

## Interface
- `DATA_WIDTH`, 16: sample width.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rtc_sec`  in  32  RTC seconds.
- `rtc_nsec`  in  32  RTC nanoseconds.
- `measure_start`  in  1  level request from trigger core.
- `measure_ready`  out  1  one-cycle pulse: settle complete, acquisition begins.
- `measure_done`  out  1  one-cycle pulse: acquisition complete and output drained.
- `ctrl_abort`  in  1  abort any measurement in progress.
- `ctrl_settle_cycles`  in  32  settle delay, latched at start acceptance.
- `ctrl_sample_count`  in  32  samples per measurement, latched at start acceptance; 0 is treated as 1.
- `s_data_tdata`  in  DATA_WIDTH  sample input.
- `s_data_tvalid`  in  1  sample valid; no backpressure is offered.
- `m_data_tdata`  out  DATA_WIDTH  sample output.
- `m_data_tvalid`  out  1  AXI-S valid.
- `m_data_tready`  in  1  AXI-S ready.
- `m_data_tlast`  out  1  marks the last sample of a measurement.
- `stat_ts_sec`, `stat_ts_nsec`  out  32 each  RTC value latched at the first accepted sample.
- `stat_meas_count`  out  32  completed measurements; wraps at 2^32.
- `stat_overrun`  out  1  sticky flag: a sample was dropped in the current or last measurement.
- `stat_busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SETTLE, ACQUIRE, FLUSH, DONE.
- IDLE:
  - `measure_start`=1 -> SETTLE.
  - Latch `ctrl_settle_cycles` into `settle_cnt` and `max(ctrl_sample_count,1)` into `n_samp`.
  - Clear `samp_cnt` and `stat_overrun`.
- SETTLE:
  - `settle_cnt`≠0: decrement each cycle.
  - `settle_cnt`==0: go to ACQUIRE and register `measure_ready`=1 for that one cycle.
  - `measure_start` falling while in SETTLE -> IDLE. No ready pulse is issued.
- ACQUIRE: `measure_start` is ignored. Each cycle with `s_data_tvalid`=1 is handled as follows.
  - Output register free (`!m_data_tvalid || m_data_tready`):
    - Load the sample and increment `samp_cnt`.
    - Set `m_data_tlast` = (`samp_cnt`==`n_samp`-1).
    - On the first load (`samp_cnt`==0), latch `rtc_sec`/`rtc_nsec` into `stat_ts_*`.
    - When the last sample is loaded -> FLUSH.
  - Output register occupied: drop the sample, do not count it, and set `stat_overrun`.
- FLUSH: wait for `m_data_tvalid && m_data_tready` on the last sample -> DONE. Samples arriving in FLUSH are ignored and do not set overrun.
- DONE:
  - Pulse `measure_done` for one cycle.
  - Increment `stat_meas_count` (modulo 2^32).
  - Go to IDLE next cycle.
- Samples arriving in IDLE, SETTLE or DONE are discarded silently.
- `ctrl_abort`=1 in any state:
  - Next state is IDLE.
  - `m_data_tvalid` and `m_data_tlast` clear next cycle; any held sample is discarded.
  - No ready or done pulse; `stat_meas_count` is unchanged; `stat_ts_*` and `stat_overrun` hold.
  - Abort has priority over every other transition.
- `m_data_tdata`/`m_data_tlast` are held stable while `m_data_tvalid && !m_data_tready`.

## Timing
- Reset: every output is 0 and the state is IDLE.
- `measure_start` high in IDLE at cycle 0:
  - SETTLE occupies cycles 1..S+1, where S = `ctrl_settle_cycles`.
  - `measure_ready` is high in cycle S+2, with state ACQUIRE.
  - Latency from start to ready is S+2 cycles.
- Sample accepted at cycle k appears on `m_data_*` at cycle k+1 (1-cycle latency).
- Last output handshake at cycle j -> DONE at j+1 with `measure_done` high at j+1 -> IDLE at j+2.
  - A new `measure_start` is accepted from cycle j+2.
- All outputs are registered; no combinational path from any input to any output.
- `stat_busy` = (state≠IDLE), registered.

## Test plan
- S=0, N=4, `m_data_tready`=1, continuous valid data 1,2,3,4 → `measure_ready` 2 cycles after start; outputs 1..4 with tlast on 4; `measure_done` 1 cycle after last handshake; `stat_meas_count`=1.
- S=10, N=1, `rtc_sec`=5, `rtc_nsec` incrementing → ready at cycle 12; `stat_ts_*` equals RTC value at the sample-accept cycle; `ctrl_sample_count`=0 behaves identically to N=1.
- N=3, `m_data_tready`=0 for 5 cycles while valid streams → `stat_overrun`=1; exactly 3 samples emitted with tlast on the 3rd; output held stable while stalled.
- `measure_start` dropped during SETTLE (S=20, drop at cycle 8) → no `measure_ready`, return to IDLE, `stat_busy`=0.
- `ctrl_abort` pulse mid-ACQUIRE with `m_data_tvalid`=1 → `m_data_tvalid`=0 next cycle; no `measure_done`; `stat_meas_count` unchanged; next start runs normally.
- Back-to-back measurements, `stat_meas_count` preset near wrap by running 2 measurements from a forced value of 0xFFFFFFFF → count wraps to 0 then 1; start in cycle j+2 accepted.
